// File: rtl/mem_ctrl.sv
// mem_ctrl: request/response SRAM sequencer; define MEM_CTRL_WRITE_VERIFY_EN to add write read-back verify
module mem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_data_out,
    output logic              ram_wrt_en,
    output logic              ram_out_en,
    output logic              ram_chip_en
);
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, VERIFY, VHOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
`endif
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    state_t     state;
    logic       wr;
    logic [3:0] cnt;
    assign req_ready = (state == IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr          <= 1'b0;
            cnt         <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_wrt_en  <= 1'b0;
            ram_out_en  <= 1'b0;
            ram_chip_en <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state       <= SETUP;
                    wr          <= req_wr;
                    ram_address <= req_addr;
                    ram_data_in <= req_wdata;
                    ram_chip_en <= 1'b1;
                end
                SETUP: begin
                    state      <= ACCESS;
                    cnt        <= CNT_INIT;
                    ram_wrt_en <= wr;
                    ram_out_en <= !wr;
                end
                ACCESS: if (cnt == '0) begin
                    state      <= HOLD;
                    ram_wrt_en <= 1'b0;
                    ram_out_en <= 1'b0;
                    if (!wr) rsp_rdata <= ram_data_out;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                    rsp_valid <= !wr;
`else
                    rsp_valid <= 1'b1;
`endif
                end else begin
                    cnt <= cnt - 4'd1;
                end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                HOLD: if (wr) begin
                    state      <= VERIFY;
                    cnt        <= CNT_INIT;
                    ram_out_en <= 1'b1;
                end else begin
                    state       <= IDLE;
                    ram_chip_en <= 1'b0;
                end
                // Read-back compare happens on the final verify cycle; result is shown in VHOLD.
                VERIFY: if (cnt == '0) begin
                    state      <= VHOLD;
                    ram_out_en <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= (ram_data_out != ram_data_in);
                end else begin
                    cnt <= cnt - 4'd1;
                end
                VHOLD: begin
                    state       <= IDLE;
                    ram_chip_en <= 1'b0;
                end
`else
                HOLD: begin
                    state       <= IDLE;
                    ram_chip_en <= 1'b0;
                end
`endif
                default: begin
                    state       <= IDLE;
                    ram_wrt_en  <= 1'b0;
                    ram_out_en  <= 1'b0;
                    ram_chip_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized check of mem_ctrl at WAIT_CYCLES 2, 1 and 15 against a transaction-level model
module tb_mem_ctrl;
    localparam int N  = 3;
    localparam int AW = 12;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    function automatic int wc(int k);
        return k == 0 ? 2 : (k == 1 ? 1 : 15);
    endfunction
    logic clk = 1'b0;
    logic rst, fill;
    logic req_valid [N], req_ready [N], req_wr [N], rsp_valid [N], rsp_err [N];
    logic ram_wrt_en [N], ram_out_en [N], ram_chip_en [N], flip [N];
    logic [AW-1:0] req_addr [N], ram_address [N];
    logic [7:0] req_wdata [N], rsp_rdata [N], ram_data_in [N], ram_data_out [N];
    logic [7:0] mem [N][1<<AW];
    int ref_mem [N][1<<AW];
    int last_rd [N];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(wc(g))) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wr(req_wr[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .ram_address(ram_address[g]), .ram_data_in(ram_data_in[g]), .ram_data_out(ram_data_out[g]),
            .ram_wrt_en(ram_wrt_en[g]), .ram_out_en(ram_out_en[g]), .ram_chip_en(ram_chip_en[g])
        );
        assign ram_data_out[g] = mem[g][ram_address[g]] ^ {7'b0, flip[g]};
    end
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (fill) begin
                for (int a = 0; a < (1 << AW); a++) mem[k][a] <= 8'(a * 7 + k);
            end else if (ram_wrt_en[k]) begin
                mem[k][ram_address[k]] <= ram_data_in[k];
            end
        end
    end
    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic txn(int i, bit wr, int a, int d, bit fl, bit keep);
        int w, lat, nw, fw, no, fo, rd, er, t, exp_rd;
        bit got, bad;
        w = wc(i);
        {lat, nw, fw, no, fo, rd, er, t} = '0;
        got = 1'b0;
        bad = 1'b0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_addr[i]  = AW'(a);
        req_wdata[i] = 8'(d);
        flip[i]      = fl && wr;
        while (!req_ready[i] && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("accept", int'(req_ready[i]), 1);
        @(posedge clk);
        #1;
        req_valid[i] = keep;
        req_wr[i]    = 1'($urandom);
        req_addr[i]  = AW'($urandom);
        req_wdata[i] = 8'($urandom);
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (ram_wrt_en[i]) begin nw++; if (fw == 0) fw = c; end
            if (ram_out_en[i]) begin no++; if (fo == 0) fo = c; end
            if ((ram_wrt_en[i] && ram_out_en[i]) || ((ram_wrt_en[i] || ram_out_en[i]) && !ram_chip_en[i])) bad = 1'b1;
            if (ram_chip_en[i] && (ram_address[i] != AW'(a) || (wr && ram_data_in[i] != 8'(d)))) bad = 1'b1;
            if (req_ready[i]) bad = 1'b1;
            if (rsp_valid[i]) begin
                got = 1'b1;
                lat = c;
                rd  = int'(rsp_rdata[i]);
                er  = int'(rsp_err[i]);
            end else if (rsp_err[i]) begin
                bad = 1'b1;
            end
        end
        flip[i] = 1'b0;
        exp_rd = wr ? last_rd[i] : ref_mem[i][a];
        check("latency", lat, (wr && VER) ? 3 + 2 * w : 2 + w);
        check("wrt_width", nw, wr ? w : 0);
        check("wrt_start", fw, wr ? 2 : 0);
        check("out_width", no, (!wr || VER) ? w : 0);
        check("out_start", fo, !wr ? 2 : (VER ? 3 + w : 0));
        check("rdata", rd, exp_rd);
        check("err", er, int'(wr && VER && fl));
        check("protocol", int'(bad), 0);
        if (wr) ref_mem[i][a] = d & 255;
        else last_rd[i] = exp_rd;
        @(posedge clk);
        #1;
        check("idle_ready", int'(req_ready[i]), 1);
        check("pulse_len", int'(rsp_valid[i]), 0);
    endtask
    initial begin
        int t;
        rst  = 1'b1;
        fill = 1'b1;
        for (int k = 0; k < N; k++) begin
            {req_valid[k], req_wr[k], flip[k]} = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            last_rd[k]   = 0;
            for (int a = 0; a < (1 << AW); a++) ref_mem[k][a] = (a * 7 + k) & 255;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_ready", int'(req_ready[k]), 1);
            check("rst_strobes", int'({ram_wrt_en[k], ram_out_en[k], ram_chip_en[k]}), 0);
            check("rst_rsp", int'({rsp_valid[k], rsp_err[k]}), 0);
            check("rst_rdata", int'(rsp_rdata[k]), 0);
            check("rst_addr", int'(ram_address[k]), 0);
            check("rst_din", int'(ram_data_in[k]), 0);
        end
        @(negedge clk);
        rst  = 1'b0;
        fill = 1'b0;
        txn(0, 1'b1, 'h123, 'hA5, 1'b0, 1'b0);
        txn(0, 1'b0, 'h123, 0, 1'b0, 1'b0);
        txn(0, 1'b0, 'h000, 0, 1'b0, 1'b1);
        txn(0, 1'b0, 'hFFF, 0, 1'b0, 1'b0);
        txn(0, 1'b1, 'h200, 'h3C, 1'b1, 1'b0);
        txn(0, 1'b1, 'h201, 'h3C, 1'b0, 1'b0);
        txn(0, 1'b0, 'h200, 0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            txn(k, 1'b1, 'h321, 'h5A, 1'b0, 1'b0);
            txn(k, 1'b0, 'h321, 0, 1'b0, 1'b0);
            for (int r = 0; r < 25; r++)
                txn(k, 1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 255)), 1'($urandom), 1'b0);
        end
        // Abort a write mid-access: the strobe already hit the RAM once, so the model keeps the data.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 12'h055;
        req_wdata[0] = 8'h99;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wrt_en", int'(ram_wrt_en[0]), 1);
        @(negedge clk);
        rst          = 1'b1;
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b0;
        @(posedge clk);
        #1;
        ref_mem[0]['h055] = 'h99;
        for (int k = 0; k < N; k++) last_rd[k] = 0;
        check("abort_strobes", int'({ram_wrt_en[0], ram_out_en[0], ram_chip_en[0]}), 0);
        check("abort_rsp", int'(rsp_valid[0]), 0);
        check("abort_ready", int'(req_ready[0]), 1);
        check("abort_rdata", int'(rsp_rdata[0]), 0);
        @(posedge clk);
        #1;
        check("rst_ignores_req", int'(ram_chip_en[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_accept", int'(ram_chip_en[0]), 1);
        req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("post_rst_rsp", int'(rsp_valid[0]), 1);
        check("post_rst_rdata", int'(rsp_rdata[0]), 'h99);
        last_rd[0] = 'h99;
        for (int k = 0; k < N; k++) begin
            txn(k, 1'b0, 'h055, 0, 1'b0, 1'b0);
            txn(k, 1'b1, 'h0AA, 'hC3, 1'b1, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: width of request and RAM address.
REQ-002 Parameter WAIT_CYCLES, default 2: cycles the RAM strobe stays asserted; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  CPU-side request present.
REQ-006 req_ready  out  1  controller can accept a request this cycle.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  target address.
REQ-009 req_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse: access complete.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid on reads.
REQ-012 rsp_err  out  1  write-verify mismatch flag, valid with rsp_valid.
REQ-013 ram_address  out  ADDR_W  drives RAM address.
REQ-014 ram_data_in  out  8  drives RAM write data.
REQ-015 ram_data_out  in  8  RAM read data (asynchronous).
REQ-016 ram_wrt_en, ram_out_en, ram_chip_en  out  1 each  RAM strobes, active-high.

Function
REQ-017 Handshake: request accepted on a rising edge where req_valid and req_ready are both 1; req_ready is 1 only in IDLE.
REQ-018 On accept, req_wr, req_addr and req_wdata are registered; RAM outputs come only from these registers, never from req_* directly.
REQ-019 FSM states: IDLE, SETUP, ACCESS, HOLD, VERIFY, VHOLD; state encoding is an implementation choice.
REQ-020 IDLE: all ram_* strobes 0; accept -> SETUP.
REQ-021 SETUP, 1 cycle: ram_chip_en=1, address/data stable, ram_wrt_en=ram_out_en=0 -> ACCESS.
REQ-022 ACCESS, exactly WAIT_CYCLES cycles: ram_chip_en=1, plus ram_wrt_en=1 for writes or ram_out_en=1 for reads; a 4-bit down-counter times this state -> HOLD.
REQ-023 Read data: ram_data_out sampled into rsp_rdata on the edge that ends the last ACCESS cycle.
REQ-024 HOLD, 1 cycle: ram_chip_en=1, strobes 0, address/data unchanged; rsp_valid=1 (except writes with verify, REQ-033) -> IDLE.
REQ-025 Latency: accept at edge N -> rsp_valid high in cycle N+2+WAIT_CYCLES (WAIT_CYCLES=2: cycle N+4).
REQ-026 Throughput: next accept no earlier than the IDLE cycle after HOLD/VHOLD; at most one request outstanding.
REQ-027 Never ram_wrt_en and ram_out_en simultaneously; never either strobe while ram_chip_en=0.
REQ-028 rsp_rdata holds the last read value; writes leave it unchanged.
REQ-029 rsp_err is 0 whenever rsp_valid is 0 and always 0 for reads.
REQ-030 req_* changes after accept have no effect on the access in flight.

Reset
REQ-031 rst=1 on any edge, in any state: next cycle state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0x00, ram_address=0, ram_data_in=0x00, all ram_* strobes 0, wait counter 0.
REQ-032 Reset mid-access aborts it with no rsp_valid pulse; req_valid during rst is ignored; first accept is possible on the first edge with rst=0.

Configuration
REQ-033 Macro MEM_CTRL_WRITE_VERIFY_EN defined: write HOLD gives no rsp_valid, goes to VERIFY (ram_chip_en=1, ram_out_en=1 for WAIT_CYCLES cycles, compare ram_data_out to registered wdata on last cycle) then VHOLD (1 cycle, strobes 0, rsp_valid=1, rsp_err=mismatch) -> IDLE; write latency N+3+2*WAIT_CYCLES.
REQ-034 Macro undefined: VERIFY/VHOLD and compare logic absent; rsp_err tied 0; writes complete per REQ-024.

Verification
REQ-035 Reset, then write 0xA5 to 0x123, WAIT_CYCLES=2, no macro -> ram_wrt_en high exactly cycles N+2..N+3, rsp_valid pulse at N+4, rsp_err=0.
REQ-036 Read 0x123 after REQ-035 with model returning 0xA5 -> ram_out_en high 2 cycles, rsp_rdata=0xA5 at rsp_valid; req_ready=0 until IDLE.
REQ-037 req_valid held high with back-to-back reads 0x000,0xFFF -> second accept only after first rsp_valid; no strobe overlap.
REQ-038 rst asserted during ACCESS of a write -> next cycle all strobes 0, no rsp_valid, req_ready=1, rsp_rdata=0x00.
REQ-039 MEM_CTRL_WRITE_VERIFY_EN, model corrupts bit 0 (writes 0x3C, reads 0x3D) -> rsp_valid at N+7, rsp_err=1; fault-free -> rsp_err=0.
REQ-040 WAIT_CYCLES=1 and 15 -> strobe width exactly 1 and 15 cycles, latency N+3 and N+17.
